// File: rtl/mb_io_regfile.sv
// -----------------------------------------------------------------------------
// mb_io_regfile
//
// Small register file hung off a MicroBlaze-style IO bus. A fixed-latency
// three-state bus FSM (IDLE -> WAIT -> ACK) accepts one transaction at a time.
// It returns IO_Ready for exactly one cycle, WAIT_STATES + 1 cycles after the
// strobe is sampled.
//
// Register map (32-bit words, word address = byte address >> 2):
//   0                 ID        read-only constant ID_VALUE
//   1                 STATUS    sticky hw_event bits, write-1-to-clear
//   2                 IRQ_MASK  read/write
//   3 .. NUM_REGS-1   GP        general purpose read/write
//   >= NUM_REGS       reads 0, writes dropped, still acknowledged
//
// Ports:
//   clk              sole clock, all state changes on its rising edge
//   reset            synchronous, active-high reset
//   IO_Addr_Strobe   transaction start qualifier
//   IO_Read_Strobe   read request (qualified by IO_Addr_Strobe)
//   IO_Write_Strobe  write request (qualified by IO_Addr_Strobe)
//   IO_Address       word address
//   IO_Byte_Enable   byte lane enables for writes
//   IO_Write_Data    write data
//   IO_Read_Data     read data, non-zero only during the ACK of a read
//   IO_Ready         one-cycle completion pulse
//   hw_event         per-bit event pulses that set STATUS bits
//   irq              registered |(STATUS & IRQ_MASK)
// -----------------------------------------------------------------------------
module mb_io_regfile #(
    parameter int          NUM_REGS    = 8,
    parameter int          ADDR_BITS   = 3,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'h4D42_0001
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 IO_Addr_Strobe,
    input  logic                 IO_Read_Strobe,
    input  logic                 IO_Write_Strobe,
    input  logic [ADDR_BITS-1:0] IO_Address,
    input  logic [3:0]           IO_Byte_Enable,
    input  logic [31:0]          IO_Write_Data,
    output logic [31:0]          IO_Read_Data,
    output logic                 IO_Ready,
    input  logic [31:0]          hw_event,
    output logic                 irq
);

    localparam logic [ADDR_BITS-1:0] ADDR_ID     = ADDR_BITS'(0);
    localparam logic [ADDR_BITS-1:0] ADDR_STATUS = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] ADDR_MASK   = ADDR_BITS'(2);
    localparam int                   FIRST_GP    = 3;

    // WAIT counts down from WAIT_STATES-1 to 0, so the ACK edge lands exactly
    // WAIT_STATES cycles after entering WAIT.
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t                 state;
    logic [3:0]             wait_cnt;
    logic                   ack_q;
    logic                   reset_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [3:0]             be_q;
    logic [31:0]            wdata_q;
    logic                   write_q;

    logic [31:0]            status;
    logic [31:0]            irq_mask;
    logic [31:0]            gp_regs [FIRST_GP:NUM_REGS-1];
    logic                   irq_q;

    logic                   start;
    logic                   commit;
    logic [31:0]            be_mask;
    logic [31:0]            status_clr;
    logic [31:0]            rd_data;

    // A transaction needs exactly one direction strobe. reset_q blanks the
    // first cycle after reset so a strobe overlapping the release is dropped.
    assign start  = IO_Addr_Strobe && (IO_Read_Strobe ^ IO_Write_Strobe) && !reset_q;

    // Writes commit at the edge that ends the ACK cycle.
    assign commit = ack_q && write_q;

    // -------------------------------------------------------------------------
    // Bus FSM with registered IO_Ready
    // -------------------------------------------------------------------------
    // NOTE: every sequential block uses non-blocking assignments so that all
    // registers sample pre-edge values; blocking here would create order-
    // dependent races between the always_ff blocks below.
    always_ff @(posedge clk) begin
        reset_q <= reset;
        if (reset) begin
            state    <= ST_IDLE;
            ack_q    <= 1'b0;
            wait_cnt <= 4'd0;
            addr_q   <= '0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
            write_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_q  <= IO_Address;
                        be_q    <= IO_Byte_Enable;
                        wdata_q <= IO_Write_Data;
                        write_q <= IO_Write_Strobe;
                        if (WAIT_STATES == 0) begin
                            state <= ST_ACK;
                            ack_q <= 1'b1;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_ACK;
                        ack_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign IO_Ready = ack_q;

    // -------------------------------------------------------------------------
    // Byte lane mask and W1C clear vector
    // -------------------------------------------------------------------------
    // NOTE: combinational blocks assign a default to every output first, so
    // no path through the block leaves a signal unassigned and no latch is
    // inferred.
    always_comb begin
        be_mask = 32'd0;
        for (int i = 0; i < 4; i++) begin
            be_mask[8*i +: 8] = {8{be_q[i]}};
        end
    end

    assign status_clr = (commit && addr_q == ADDR_STATUS) ? (wdata_q & be_mask) : 32'd0;

    // -------------------------------------------------------------------------
    // STATUS: hardware sets win over a same-cycle software clear
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            status <= 32'd0;
        end else begin
            status <= (status & ~status_clr) | hw_event;
        end
    end

    // -------------------------------------------------------------------------
    // IRQ_MASK
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask <= 32'd0;
        end else if (commit && addr_q == ADDR_MASK) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    irq_mask[8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // General purpose words
    // -------------------------------------------------------------------------
    // NOTE: the GP array is a handful of flops that software expects to read
    // as zero after reset, so it is cleared explicitly; a large RAM-style array
    // would normally be left unreset so it can map onto memory macros.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = FIRST_GP; w < NUM_REGS; w++) begin
                gp_regs[w] <= 32'd0;
            end
        end else if (commit) begin
            for (int w = FIRST_GP; w < NUM_REGS; w++) begin
                if (addr_q == ADDR_BITS'(w)) begin
                    for (int i = 0; i < 4; i++) begin
                        if (be_q[i]) begin
                            gp_regs[w][8*i +: 8] <= wdata_q[8*i +: 8];
                        end
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Interrupt: one cycle behind STATUS/IRQ_MASK
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(status & irq_mask);
        end
    end

    assign irq = irq_q;

    // -------------------------------------------------------------------------
    // Read mux: driven only during the ACK of a read. STATUS is read from the
    // live register, i.e. the value held at the start of the ACK cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        rd_data = 32'd0;
        if (ack_q && !write_q) begin
            if (addr_q == ADDR_ID) begin
                rd_data = ID_VALUE;
            end else if (addr_q == ADDR_STATUS) begin
                rd_data = status;
            end else if (addr_q == ADDR_MASK) begin
                rd_data = irq_mask;
            end else begin
                for (int w = FIRST_GP; w < NUM_REGS; w++) begin
                    if (addr_q == ADDR_BITS'(w)) begin
                        rd_data = gp_regs[w];
                    end
                end
            end
        end
    end

    assign IO_Read_Data = rd_data;

endmodule

// File: tb/tb_mb_io_regfile.sv
// -----------------------------------------------------------------------------
// tb_mb_io_regfile
//
// Two instances share clock and reset: index 0 runs with WAIT_STATES=0 and
// index 1 with WAIT_STATES=3. Both use ADDR_BITS=4 so that addresses at and
// beyond NUM_REGS are reachable. A register-array model predicts every read,
// the latency and the irq level.
// -----------------------------------------------------------------------------
module tb_mb_io_regfile;

    localparam int          NR = 8;
    localparam int          AB = 4;
    localparam logic [31:0] ID = 32'h4D42_0001;

    typedef struct packed {
        logic          astb;
        logic          rstb;
        logic          wstb;
        logic [AB-1:0] addr;
        logic [3:0]    be;
        logic [31:0]   wd;
        logic [31:0]   ev;
    } bus_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    bus_t        bi    [2];
    logic [31:0] rdata [2];
    logic        rdy   [2];
    logic        irq_o [2];

    int vectors     = 0;
    int miscompares = 0;

    // Model: word 1 = STATUS, word 2 = IRQ_MASK, 3..NR-1 = GP; word 0 unused.
    logic [31:0] m_word [2][NR];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mb_io_regfile #(
            .NUM_REGS   (NR),
            .ADDR_BITS  (AB),
            .WAIT_STATES(3 * g),
            .ID_VALUE   (ID)
        ) dut (
            .clk            (clk),
            .reset          (reset),
            .IO_Addr_Strobe (bi[g].astb),
            .IO_Read_Strobe (bi[g].rstb),
            .IO_Write_Strobe(bi[g].wstb),
            .IO_Address     (bi[g].addr),
            .IO_Byte_Enable (bi[g].be),
            .IO_Write_Data  (bi[g].wd),
            .IO_Read_Data   (rdata[g]),
            .IO_Ready       (rdy[g]),
            .hw_event       (bi[g].ev),
            .irq            (irq_o[g])
        );
    end

    // ------------------------------------------------------------------ model
    function automatic int ws(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m = 32'd0;
        for (int i = 0; i < 4; i++) if (be[i]) m = m + (32'hFF << (8 * i));
        return m;
    endfunction

    function automatic logic [31:0] exp_read(input int d, input int a);
        if (a == 0) return ID;
        if (a < NR) return m_word[d][a];
        return 32'd0;
    endfunction

    function automatic logic exp_irq(input int d);
        return (m_word[d][1] & m_word[d][2]) != 32'd0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) for (int a = 0; a < NR; a++) m_word[d][a] = 32'd0;
    endtask

    task automatic model_write(input int d, input int a, input logic [3:0] be,
                               input logic [31:0] data, input logic [31:0] ack_ev);
        logic [31:0] m = lane_mask(be);
        if (a == 1) m_word[d][1] = m_word[d][1] & ~(data & m);
        else if (a >= 2 && a < NR) m_word[d][a] = (m_word[d][a] & ~m) | (data & m);
        m_word[d][1] = m_word[d][1] | ack_ev;
    endtask

    // ------------------------------------------------------------ bus driver
    // Drives one strobe, waits for IO_Ready (bounded), reports latency in
    // cycles (-1 on timeout), the data seen during ACK and whether any
    // non-zero data or extra ready appeared outside ACK. ack_ev is applied to
    // hw_event during the ACK cycle, i.e. at the commit edge.
    task automatic bus_txn(input int d, input bit wr, input int a, input logic [3:0] be,
                           input logic [31:0] data, input logic [31:0] ack_ev,
                           output int lat, output logic [31:0] rd_val, output bit stray);
        @(negedge clk);
        bi[d].astb = 1'b1;
        bi[d].rstb = !wr;
        bi[d].wstb = wr;
        bi[d].addr = AB'(a);
        bi[d].be   = be;
        bi[d].wd   = data;
        lat    = -1;
        rd_val = 32'd0;
        stray  = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            bi[d].astb = 1'b0;
            bi[d].rstb = 1'b0;
            bi[d].wstb = 1'b0;
            if (rdy[d] === 1'b1) begin
                lat      = n;
                rd_val   = rdata[d];
                bi[d].ev = ack_ev;
                break;
            end else if (rdata[d] !== 32'd0) begin
                stray = 1'b1;
            end
        end
        @(negedge clk);
        bi[d].ev = 32'd0;
        if (rdy[d] !== 1'b0 || rdata[d] !== 32'd0) stray = 1'b1;
    endtask

    task automatic write_reg(input int d, input int a, input logic [3:0] be, input logic [31:0] data,
                             input logic [31:0] ack_ev, output int lat, output bit stray);
        logic [31:0] dummy;
        bus_txn(d, 1'b1, a, be, data, ack_ev, lat, dummy, stray);
        model_write(d, a, be, data, ack_ev);
    endtask

    task automatic read_reg(input int d, input int a, output int lat,
                            output logic [31:0] rv, output bit stray);
        bus_txn(d, 1'b0, a, 4'h0, 32'd0, 32'd0, lat, rv, stray);
    endtask

    task automatic pulse_event(input int d, input logic [31:0] ev);
        @(negedge clk);
        bi[d].ev = ev;
        @(negedge clk);
        bi[d].ev = 32'd0;
        m_word[d][1] = m_word[d][1] | ev;
    endtask

    // ----------------------------------------------------------------- tests
    task automatic test_reset();
        int lat; logic [31:0] rv; bit st; int seen [2];
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (rdy[d] !== 1'b0 || rdata[d] !== 32'd0 || irq_o[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_outputs dut%0d: ready=%b data=%h irq=%b, want 0/0/0",
                         d, rdy[d], rdata[d], irq_o[d]);
            end
        end
        // Strobe in the first cycle with reset low must be dropped.
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            bi[d].astb = 1'b1; bi[d].rstb = 1'b1; bi[d].addr = '0;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            bi[d].astb = 1'b0; bi[d].rstb = 1'b0; seen[d] = 0;
        end
        for (int n = 0; n < 8; n++) begin
            for (int d = 0; d < 2; d++) if (rdy[d] !== 1'b0) seen[d]++;
            @(negedge clk);
        end
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (seen[d] != 0) begin
                miscompares++;
                $display("FAIL strobe_at_release dut%0d: %0d ready cycles, want 0", d, seen[d]);
            end
        end
        // A strobe one cycle after release is accepted with normal latency.
        for (int d = 0; d < 2; d++) begin
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
            read_reg(d, 0, lat, rv, st);
            vectors++;
            if (lat !== 1 + ws(d) || rv !== ID) begin
                miscompares++;
                $display("FAIL strobe_after_release dut%0d: lat=%0d data=%h, want lat=%0d data=%h",
                         d, lat, rv, 1 + ws(d), ID);
            end
        end
        model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int a = 1; a < NR; a++) begin
                read_reg(d, a, lat, rv, st);
                vectors++;
                if (rv !== 32'd0) begin
                    miscompares++;
                    $display("FAIL reset_value dut%0d word%0d: got %h want 00000000", d, a, rv);
                end
            end
        end
    endtask

    task automatic test_id_read();
        int lat; logic [31:0] rv; bit st;
        for (int d = 0; d < 2; d++) begin
            read_reg(d, 0, lat, rv, st);
            vectors++;
            if (lat !== 1 + ws(d) || rv !== ID || st) begin
                miscompares++;
                $display("FAIL id_read dut%0d: lat=%0d data=%h stray=%0b, want lat=%0d data=%h stray=0",
                         d, lat, rv, st, 1 + ws(d), ID);
            end
            write_reg(d, 0, 4'hF, 32'h1234_5678, 32'd0, lat, st);
            read_reg(d, 0, lat, rv, st);
            vectors++;
            if (rv !== ID) begin
                miscompares++;
                $display("FAIL id_write_ignored dut%0d: got %h want %h", d, rv, ID);
            end
        end
    endtask

    task automatic test_byte_lanes();
        int lat; logic [31:0] rv; bit st;
        for (int d = 0; d < 2; d++) begin
            write_reg(d, 3, 4'b0101, 32'hAABB_CCDD, 32'd0, lat, st);
            vectors++;
            if (lat !== 1 + ws(d) || st) begin
                miscompares++;
                $display("FAIL write_ack dut%0d: lat=%0d stray=%0b, want lat=%0d stray=0",
                         d, lat, st, 1 + ws(d));
            end
            read_reg(d, 3, lat, rv, st);
            vectors++;
            if (rv !== 32'h00BB_00DD) begin
                miscompares++;
                $display("FAIL byte_lanes_0101 dut%0d: got %h want 00bb00dd", d, rv);
            end
            write_reg(d, 3, 4'b1010, 32'h1122_3344, 32'd0, lat, st);
            read_reg(d, 3, lat, rv, st);
            vectors++;
            if (rv !== 32'h11BB_33DD) begin
                miscompares++;
                $display("FAIL byte_lanes_1010 dut%0d: got %h want 11bb33dd", d, rv);
            end
        end
    endtask

    task automatic test_irq();
        int lat; logic [31:0] rv; bit st;
        write_reg(0, 2, 4'hF, 32'h0000_0010, 32'd0, lat, st);
        pulse_event(0, 32'h0000_0010);
        vectors++;
        if (irq_o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_lag: irq=%b one cycle after set, want 0", irq_o[0]);
        end
        @(negedge clk);
        vectors++;
        if (irq_o[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_assert: irq=%b, want 1", irq_o[0]);
        end
        read_reg(0, 1, lat, rv, st);
        vectors++;
        if (rv !== 32'h10) begin
            miscompares++;
            $display("FAIL status_set: got %h want 00000010", rv);
        end
        write_reg(0, 1, 4'hF, 32'h0000_0010, 32'd0, lat, st);
        @(negedge clk);
        vectors++;
        if (irq_o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_clear: irq=%b, want 0", irq_o[0]);
        end
        read_reg(0, 1, lat, rv, st);
        vectors++;
        if (rv !== 32'd0) begin
            miscompares++;
            $display("FAIL status_w1c: got %h want 00000000", rv);
        end
        // Event in the commit cycle of the clear: the set wins.
        pulse_event(0, 32'h0000_0010);
        write_reg(0, 1, 4'hF, 32'h0000_0010, 32'h0000_0010, lat, st);
        @(negedge clk);
        vectors++;
        if (irq_o[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_set_wins: irq=%b, want 1", irq_o[0]);
        end
        read_reg(0, 1, lat, rv, st);
        vectors++;
        if (rv !== 32'h10) begin
            miscompares++;
            $display("FAIL status_set_wins: got %h want 00000010", rv);
        end
        write_reg(0, 1, 4'hF, 32'hFFFF_FFFF, 32'd0, lat, st);
        write_reg(0, 2, 4'hF, 32'd0, 32'd0, lat, st);
    endtask

    task automatic test_wait_drop();
        int lat; logic [31:0] rv; bit st;
        int ready_cnt = 0; int first = -1; logic [31:0] data_at = 32'd0;
        @(negedge clk);
        bi[1].astb = 1'b1; bi[1].rstb = 1'b1; bi[1].wstb = 1'b0; bi[1].addr = AB'(0);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            bi[1].astb = 1'b0; bi[1].rstb = 1'b0; bi[1].wstb = 1'b0;
            if (n == 1) begin
                // Second request while in WAIT.
                bi[1].astb = 1'b1; bi[1].wstb = 1'b1; bi[1].addr = AB'(4);
                bi[1].be = 4'hF; bi[1].wd = 32'hFFFF_FFFF;
            end
            if (rdy[1] === 1'b1) begin
                ready_cnt++;
                if (first < 0) begin
                    first = n; data_at = rdata[1];
                    // Third request while in ACK.
                    bi[1].astb = 1'b1; bi[1].wstb = 1'b1; bi[1].addr = AB'(5);
                    bi[1].be = 4'hF; bi[1].wd = 32'hFFFF_FFFF;
                end
            end
        end
        vectors++;
        if (ready_cnt != 1 || first != 4 || data_at !== ID) begin
            miscompares++;
            $display("FAIL wait_drop: readies=%0d first=%0d data=%h, want 1/4/%h",
                     ready_cnt, first, data_at, ID);
        end
        for (int a = 4; a <= 5; a++) begin
            read_reg(1, a, lat, rv, st);
            vectors++;
            if (rv !== exp_read(1, a)) begin
                miscompares++;
                $display("FAIL dropped_write word%0d: got %h want %h", a, rv, exp_read(1, a));
            end
        end
    endtask

    task automatic test_bad_strobe();
        int seen [2];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                bi[d].astb = (k != 2);
                bi[d].rstb = (k == 0 || k == 2);
                bi[d].wstb = (k == 0);
                bi[d].addr = AB'(3); bi[d].be = 4'hF; bi[d].wd = 32'hFFFF_FFFF;
                seen[d] = 0;
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                bi[d].astb = 1'b0; bi[d].rstb = 1'b0; bi[d].wstb = 1'b0;
            end
            for (int n = 0; n < 6; n++) begin
                for (int d = 0; d < 2; d++) if (rdy[d] !== 1'b0) seen[d]++;
                @(negedge clk);
            end
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (seen[d] != 0) begin
                    miscompares++;
                    $display("FAIL bad_strobe%0d dut%0d: %0d ready cycles, want 0", k, d, seen[d]);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rv; bit st;
        for (int d = 0; d < 2; d++) begin
            read_reg(d, NR, lat, rv, st);
            vectors++;
            if (lat !== 1 + ws(d) || rv !== 32'd0 || st) begin
                miscompares++;
                $display("FAIL oor_read dut%0d: lat=%0d data=%h, want lat=%0d data=0", d, lat, rv, 1 + ws(d));
            end
            write_reg(d, NR, 4'hF, 32'hFFFF_FFFF, 32'd0, lat, st);
            vectors++;
            if (lat !== 1 + ws(d)) begin
                miscompares++;
                $display("FAIL oor_write_ack dut%0d: lat=%0d want %0d", d, lat, 1 + ws(d));
            end
            write_reg(d, 15, 4'hF, 32'hFFFF_FFFF, 32'd0, lat, st);
            for (int a = 1; a < NR; a++) begin
                read_reg(d, a, lat, rv, st);
                vectors++;
                if (rv !== exp_read(d, a)) begin
                    miscompares++;
                    $display("FAIL oor_no_side_effect dut%0d word%0d: got %h want %h", d, a, rv, exp_read(d, a));
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] rv; bit st; int seen = 0;
        @(negedge clk);
        bi[1].astb = 1'b1; bi[1].wstb = 1'b1; bi[1].rstb = 1'b0;
        bi[1].addr = AB'(5); bi[1].be = 4'hF; bi[1].wd = 32'hDEAD_BEEF;
        @(negedge clk);
        bi[1].astb = 1'b0; bi[1].wstb = 1'b0;
        if (rdy[1] !== 1'b0) seen++;
        @(negedge clk);
        if (rdy[1] !== 1'b0) seen++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int n = 0; n < 8; n++) begin
            if (rdy[1] !== 1'b0) seen++;
            @(negedge clk);
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL reset_abort_ready: %0d ready cycles, want 0", seen);
        end
        read_reg(1, 5, lat, rv, st);
        vectors++;
        if (rv !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_abort_data: word5=%h want 00000000", rv);
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rv; bit st;
        for (int it = 0; it < 120; it++) begin
            int d    = int'($urandom_range(1, 0));
            int kind = int'($urandom_range(3, 0));
            int a    = ($urandom_range(7, 0) == 0) ? 15 : int'($urandom_range(NR + 1, 0));
            logic [3:0]  be   = 4'($urandom);
            logic [31:0] data = $urandom;
            logic [31:0] aev  = ($urandom_range(3, 0) == 0) ? (32'd1 << $urandom_range(31, 0)) : 32'd0;
            if (kind == 0) begin
                pulse_event(d, ($urandom_range(1, 0) == 1) ? $urandom : (32'd1 << $urandom_range(31, 0)));
            end else if (kind == 1) begin
                write_reg(d, a, be, data, aev, lat, st);
                vectors++;
                if (lat !== 1 + ws(d) || st) begin
                    miscompares++;
                    $display("FAIL rand_write dut%0d word%0d: lat=%0d stray=%0b, want lat=%0d",
                             d, a, lat, st, 1 + ws(d));
                end
            end else begin
                read_reg(d, a, lat, rv, st);
                vectors++;
                if (lat !== 1 + ws(d) || st || rv !== exp_read(d, a)) begin
                    miscompares++;
                    $display("FAIL rand_read dut%0d word%0d: lat=%0d data=%h stray=%0b, want lat=%0d data=%h",
                             d, a, lat, rv, st, 1 + ws(d), exp_read(d, a));
                end
            end
            @(negedge clk);
            vectors++;
            if (irq_o[d] !== exp_irq(d)) begin
                miscompares++;
                $display("FAIL rand_irq dut%0d iter%0d: irq=%b want %b", d, it, irq_o[d], exp_irq(d));
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) bi[d] = '0;
        model_reset();
        test_reset();
        test_id_read();
        test_byte_lanes();
        test_irq();
        test_wait_drop();
        test_bad_strobe();
        test_out_of_range();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
